// File: rtl/uart_tx_nbyte.sv
// N-byte UART transmitter: latches an 8*NUM_BYTES word on start/ready and sends it as
// NUM_BYTES back-to-back 8N1/8N2 frames, baud timing from an internal tick counter.
module uart_tx_nbyte #(
   parameter int NUM_BYTES    = 16,
   parameter int CLKS_PER_BIT = 1085,
   parameter int STOP_BITS    = 1,
   parameter int MSB_BYTE_1ST = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [8*NUM_BYTES-1:0] tx_data,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [5:0]             byte_cnt,
   output logic                   tx_out
);

   localparam int              DW        = 8 * NUM_BYTES;
   localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [5:0]      BYTE_LAST = 6'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state_r;
   logic [DW-1:0]   shift_r;
   logic [CW-1:0]   baud_r;
   logic [3:0]      bit_r;
   logic [5:0]      byte_cnt_r;
   logic            tx_r;
   logic            ready_r;
   logic            busy_r;
   logic            done_r;

   logic [7:0]      cur_byte_s;
   logic [3:0]      bit_nxt_s;
   logic            bit_end_s;

   // Byte currently on the line and bit-boundary decode.
   always_comb begin
      cur_byte_s = (MSB_BYTE_1ST != 0) ? shift_r[DW-1 -: 8] : shift_r[7:0];
      bit_nxt_s  = bit_r + 4'd1;
      bit_end_s  = (baud_r == BAUD_LAST);
   end

   // Transmit FSM; every output is a register so the line never glitches.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         shift_r    <= '0;
         baud_r     <= '0;
         bit_r      <= 4'd0;
         byte_cnt_r <= 6'd0;
         tx_r       <= 1'b1;
         ready_r    <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               baud_r     <= '0;
               bit_r      <= 4'd0;
               byte_cnt_r <= 6'd0;
               done_r     <= 1'b0;
               tx_r       <= 1'b1;
               if (start) begin
                  shift_r <= tx_data;
                  state_r <= START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
               end else begin
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
               end
            end
            START: begin
               if (bit_end_s) begin
                  baud_r  <= '0;
                  bit_r   <= 4'd0;
                  tx_r    <= cur_byte_s[0];
                  state_r <= DATA;
               end else begin
                  baud_r <= baud_r + 1'b1;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  baud_r <= '0;
                  if (bit_r == 4'd7) begin
                     bit_r   <= 4'd0;
                     tx_r    <= 1'b1;
                     state_r <= STOP;
                  end else begin
                     bit_r <= bit_nxt_s;
                     tx_r  <= cur_byte_s[bit_nxt_s[2:0]];
                  end
               end else begin
                  baud_r <= baud_r + 1'b1;
               end
            end
            STOP: begin
               if (bit_end_s) begin
                  baud_r <= '0;
                  if (bit_r == STOP_LAST) begin
                     bit_r <= 4'd0;
                     if (byte_cnt_r == BYTE_LAST) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        tx_r    <= 1'b1;
                     end else begin
                        // Next start bit follows the stop bit(s) with no idle gap.
                        state_r    <= START;
                        tx_r       <= 1'b0;
                        byte_cnt_r <= byte_cnt_r + 6'd1;
                        if (MSB_BYTE_1ST != 0) begin
                           shift_r <= shift_r << 4'd8;
                        end else begin
                           shift_r <= shift_r >> 4'd8;
                        end
                     end
                  end else begin
                     bit_r <= bit_nxt_s;
                  end
               end else begin
                  baud_r <= baud_r + 1'b1;
               end
            end
            DONE: begin
               done_r     <= 1'b0;
               ready_r    <= 1'b1;
               busy_r     <= 1'b0;
               tx_r       <= 1'b1;
               byte_cnt_r <= 6'd0;
               state_r    <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               baud_r  <= '0;
               bit_r   <= 4'd0;
            end
         endcase
      end
   end

   assign ready    = ready_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign byte_cnt = byte_cnt_r;
   assign tx_out   = tx_r;

endmodule
